// File: rtl/rr_decode_arbiter_if.sv
// rr_decode_arbiter_if: request/release and grant signals between requesters and rr_decode_arbiter
interface rr_decode_arbiter_if;
  logic [3:0] req;
  logic       done;
  logic [3:0] gnt;
  logic [1:0] gnt_idx;
  logic       gnt_valid;
  logic       timeout;
  modport master (output req, done, input gnt, gnt_idx, gnt_valid, timeout);
  modport slave  (input req, done, output gnt, gnt_idx, gnt_valid, timeout);
endinterface

// File: rtl/rr_decode_arbiter.sv
// rr_decode_arbiter: 4-way round-robin arbiter, registered owner index decoded to a one-hot grant; define ARB_TIMEOUT_EN to force-release grants after HOLD_MAX cycles
module rr_decode_arbiter #(
  parameter int HOLD_MAX = 16,
  parameter int CNT_W    = 8
) (
  input logic                clk,
  input logic                rst,
  rr_decode_arbiter_if.slave bus
);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t     state, state_n;
  logic [1:0] ptr, ptr_n, idx, idx_n, win;
  logic [3:0] gnt, gnt_n;
  logic       valid, valid_n, rel, force_rel;
  if (HOLD_MAX < 2 || HOLD_MAX > 255 || (2 ** CNT_W) <= HOLD_MAX) begin : g_bad_cfg
    $error("rr_decode_arbiter: illegal HOLD_MAX/CNT_W combination");
  end
  assign rel = bus.done || !bus.req[idx];
  // scan from ptr+1 upward; the previous owner (ptr itself) is checked last
  always_comb begin
    win = ptr;
    for (int k = 4; k >= 1; k--) win = bus.req[ptr + 2'(k)] ? ptr + 2'(k) : win;
  end
`ifdef ARB_TIMEOUT_EN
  logic [CNT_W-1:0] cnt;
  logic             timeout;
  assign force_rel   = cnt == CNT_W'(HOLD_MAX - 1);
  assign bus.timeout = timeout;
  // hold counter restarts each grant; timeout flags a forced release not masked by a normal one
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      timeout <= 1'b0;
    end else begin
      cnt     <= state == GRANT ? cnt + 1'b1 : '0;
      timeout <= state == GRANT && force_rel && !rel;
    end
  end
`else
  assign force_rel   = 1'b0;
  assign bus.timeout = 1'b0;
`endif
  // state and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      ptr   <= 2'b11;
      idx   <= '0;
      gnt   <= '0;
      valid <= 1'b0;
    end else begin
      state <= state_n;
      ptr   <= ptr_n;
      idx   <= idx_n;
      gnt   <= gnt_n;
      valid <= valid_n;
    end
  end
  // grant on any request from IDLE; release on done, owner drop or hold limit
  always_comb state_n = state == IDLE ? (|bus.req ? GRANT : IDLE) : (rel || force_rel ? IDLE : GRANT);
  // next register values: decode winner on grant, clear grant and rotate pointer on release
  always_comb begin
    ptr_n   = ptr;
    idx_n   = idx;
    gnt_n   = gnt;
    valid_n = valid;
    if (state == IDLE && state_n == GRANT) begin
      idx_n   = win;
      gnt_n   = 4'b0001 << win;
      valid_n = 1'b1;
    end
    if (state == GRANT && state_n == IDLE) begin
      ptr_n   = idx;
      gnt_n   = '0;
      valid_n = 1'b0;
    end
  end
  assign bus.gnt       = gnt;
  assign bus.gnt_idx   = idx;
  assign bus.gnt_valid = valid;
endmodule
